// File: rtl/adc_i2c_target.sv
// adc_i2c_target: I2C target emulating the 16-bit pointer/config/conversion register map of a distance-sensor ADC.
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   scl_pin     I2C clock (sampled only)
//   sda_pin     I2C data, open-drain (driven 0 or released)
//   adc_sample  live conversion value served at pointer 0
//   config_reg  config register contents (pointer 1)
//   config_wr   one-clock strobe when config_reg is written
//   busy        high while a transaction addressed to this target is in progress
module adc_i2c_target #(
    parameter logic [6:0]  TARGET_ADDR  = 7'h48,
    parameter logic [15:0] CONFIG_RESET = 16'h8583
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl_pin,
    inout  wire         sda_pin,
    input  logic [15:0] adc_sample,
    output logic [15:0] config_reg,
    output logic        config_wr,
    output logic        busy
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;
    state_t      r_state;
    logic        r_scl_s1, r_scl_s2, r_scl_d;
    logic        r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [1:0]  r_ptr;
    logic        r_byte_idx;
    logic [7:0]  r_msb;
    logic [15:0] r_rd_word;
    logic        r_sda_oe;
    logic        r_busy;
    logic [15:0] r_config;
    logic        r_config_wr;
    logic        w_scl_rise, w_scl_fall, w_start, w_stop, w_last, w_match;
    logic [7:0]  w_byte;
    logic [15:0] w_rd_sel;
    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
    assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
    assign w_byte     = {r_shift[6:0], r_sda_s2};
    assign w_last     = r_bit_cnt == 4'd7;
    assign w_match    = w_byte[7:1] == TARGET_ADDR;
    assign w_rd_sel   = (r_ptr == 2'd0) ? adc_sample : (r_ptr == 2'd1) ? r_config : 16'h0000;
    assign sda_pin    = r_sda_oe ? 1'b0 : 1'bz;
    assign config_reg = r_config;
    assign config_wr  = r_config_wr;
    assign busy       = r_busy;
    // Synchronizers idle high so reset never looks like a bus edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_pin, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_pin, r_sda_s1, r_sda_s2};
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_byte_idx  <= 1'b0;
            r_msb       <= '0;
            r_rd_word   <= '0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_config    <= CONFIG_RESET;
            r_config_wr <= 1'b0;
        end else begin
            r_config_wr <= 1'b0;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: if (w_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_last) begin
                            r_state <= w_match ? S_ADDR_ACK : S_IGNORE;
                            r_busy  <= w_match;
                        end
                    end
                    S_PTR: if (w_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_last) begin
                            r_state <= S_PTR_ACK;
                            r_ptr   <= w_byte[1:0];
                        end
                    end
                    S_WR_DATA: if (w_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_last) begin
                            r_state    <= S_WR_ACK;
                            r_byte_idx <= ~r_byte_idx;
                            if (!r_byte_idx)
                                r_msb <= w_byte;
                            else if (r_ptr == 2'd1) begin
                                r_config    <= {r_msb, w_byte};
                                r_config_wr <= 1'b1;
                            end
                        end
                    end
                    // ACK phases: the first scl_fall pulls sda low, the second releases it.
                    // r_shift[0] still holds the R/W bit while in S_ADDR_ACK.
                    S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: if (w_scl_fall) begin
                        r_bit_cnt <= '0;
                        if (!r_sda_oe)
                            r_sda_oe <= 1'b1;
                        else if (r_state == S_ADDR_ACK && r_shift[0]) begin
                            r_state    <= S_RD_DATA;
                            r_rd_word  <= w_rd_sel;
                            r_shift    <= w_rd_sel[15:8];
                            r_sda_oe   <= ~w_rd_sel[15];
                            r_byte_idx <= 1'b0;
                        end else begin
                            r_sda_oe   <= 1'b0;
                            r_state    <= (r_state == S_ADDR_ACK) ? S_PTR : S_WR_DATA;
                            r_byte_idx <= (r_state == S_WR_ACK) ? r_byte_idx : 1'b0;
                        end
                    end
                    // r_shift[7] is already on the bus; each fall presents the next bit.
                    S_RD_DATA: begin
                        if (w_scl_rise)
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_state  <= S_RD_ACK;
                            r_sda_oe <= 1'b0;
                        end else if (w_scl_fall) begin
                            r_sda_oe <= ~r_shift[6];
                            r_shift  <= {r_shift[6:0], 1'b0};
                        end
                    end
                    // A fall here is only reached after the master ACKed on the rise.
                    S_RD_ACK: if (w_scl_rise && r_sda_s2) begin
                        r_state <= S_IGNORE;
                        r_busy  <= 1'b0;
                    end else if (w_scl_fall) begin
                        r_state    <= S_RD_DATA;
                        r_bit_cnt  <= '0;
                        r_byte_idx <= ~r_byte_idx;
                        if (r_byte_idx) begin
                            r_rd_word <= w_rd_sel;
                            r_shift   <= w_rd_sel[15:8];
                            r_sda_oe  <= ~w_rd_sel[15];
                        end else begin
                            r_shift  <= r_rd_word[7:0];
                            r_sda_oe <= ~r_rd_word[7];
                        end
                    end
                    S_IDLE, S_IGNORE: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_i2c_target.sv
// tb_adc_i2c_target: bit-banged I2C master driving adc_i2c_target through directed transaction vectors.
module tb_adc_i2c_target;
    localparam int Q = 10;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl = 1'b1;
    logic        m_oe = 1'b0;
    logic [15:0] adc_sample = 16'h0000;
    logic [15:0] config_reg;
    logic        config_wr;
    logic        busy;
    wire         sda_pin;
    int          n_vec = 0;
    int          n_err = 0;
    int          wr_hi = 0;
    int          busy_hi = 0;
    pullup (sda_pin);
    assign sda_pin = m_oe ? 1'b0 : 1'bz;
    always #4 clk = ~clk;
    always @(posedge clk) begin
        if (config_wr) wr_hi <= wr_hi + 1;
        if (busy) busy_hi <= busy_hi + 1;
    end
    adc_i2c_target dut (
        .clk(clk), .reset_n(reset_n), .scl_pin(scl), .sda_pin(sda_pin),
        .adc_sample(adc_sample), .config_reg(config_reg), .config_wr(config_wr), .busy(busy)
    );
    typedef struct {
        logic [7:0]       addr;
        int               nwr;
        logic [0:2][7:0]  wb;
        logic [15:0]      adc;
        int               nrd;
        logic             exp_ack;
        logic [15:0]      exp_cfg;
        int               exp_wr;
        logic [0:1][7:0]  exp_rd;
    } vec_t;
    vec_t vecs[8];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask
    task automatic hq();
        repeat (Q) @(negedge clk);
    endtask
    task automatic i2c_start();
        m_oe = 1'b0; hq(); scl = 1'b1; hq(); m_oe = 1'b1; hq(); scl = 1'b0; hq();
    endtask
    task automatic i2c_stop();
        m_oe = 1'b1; hq(); scl = 1'b1; hq(); m_oe = 1'b0; hq();
    endtask
    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_oe = ~b[i]; hq(); scl = 1'b1; hq(); hq(); scl = 1'b0; hq();
        end
    endtask
    task automatic ack_bit(output logic a);
        m_oe = 1'b0; hq(); scl = 1'b1; hq(); a = (sda_pin == 1'b0); hq(); scl = 1'b0; hq();
    endtask
    task automatic write_byte(input logic [7:0] b, output logic a);
        send_bits(b);
        ack_bit(a);
    endtask
    task automatic read_byte(output logic [7:0] b, input logic nack);
        m_oe = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            hq(); scl = 1'b1; hq(); b[i] = sda_pin; hq(); scl = 1'b0;
        end
        hq(); m_oe = ~nack; hq(); scl = 1'b1; hq(); hq(); scl = 1'b0; hq();
    endtask
    initial begin
        logic       a;
        logic [7:0] b, b1;
        int         wr0, busy0;
        vecs[0] = '{8'h90, 3, {8'h01, 8'h42, 8'h83}, 16'h0000, 0, 1'b1, 16'h4283, 1, {8'h00, 8'h00}};
        vecs[1] = '{8'h90, 1, {8'h00, 8'h00, 8'h00}, 16'hABCD, 2, 1'b1, 16'h4283, 0, {8'hAB, 8'hCD}};
        vecs[2] = '{8'h92, 3, {8'h01, 8'h55, 8'h66}, 16'h0000, 0, 1'b0, 16'h4283, 0, {8'h00, 8'h00}};
        vecs[3] = '{8'h90, 2, {8'h01, 8'h12, 8'h00}, 16'h0000, 0, 1'b1, 16'h4283, 0, {8'h00, 8'h00}};
        vecs[4] = '{8'h90, 3, {8'h01, 8'hBE, 8'hEF}, 16'h0000, 2, 1'b1, 16'hBEEF, 1, {8'hBE, 8'hEF}};
        vecs[5] = '{8'h90, 1, {8'h03, 8'h00, 8'h00}, 16'h5555, 2, 1'b1, 16'hBEEF, 0, {8'h00, 8'h00}};
        vecs[6] = '{8'h90, 3, {8'hFD, 8'h12, 8'h34}, 16'h5555, 2, 1'b1, 16'h1234, 1, {8'h12, 8'h34}};
        vecs[7] = '{8'h90, 3, {8'h02, 8'hAA, 8'hBB}, 16'h7E81, 2, 1'b1, 16'h1234, 0, {8'h00, 8'h00}};
        repeat (4) @(negedge clk);
        chk("rst_config", config_reg, 16'h8583);
        chk("rst_config_wr", config_wr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sda", sda_pin, 1'b1);
        reset_n = 1'b1;
        hq();
        // Pointer 1, repeated START, 4-byte read wrapping over the reset config value.
        i2c_start();
        write_byte(8'h90, a); chk("rs_addr_ack", a, 1'b1);
        chk("rs_busy", busy, 1'b1);
        write_byte(8'h01, a); chk("rs_ptr_ack", a, 1'b1);
        i2c_start();
        write_byte(8'h91, a); chk("rs_raddr_ack", a, 1'b1);
        for (int j = 0; j < 4; j++) begin
            read_byte(b, j == 3);
            chk($sformatf("rs_rd%0d", j), b, (j % 2 == 0) ? 8'h85 : 8'h83);
        end
        chk("rs_sda_rel", sda_pin, 1'b1);
        i2c_stop(); hq();
        chk("rs_busy_end", busy, 1'b0);
        for (int v = 0; v < 8; v++) begin
            wr0 = wr_hi;
            busy0 = busy_hi;
            adc_sample = vecs[v].adc;
            i2c_start();
            write_byte(vecs[v].addr, a);
            chk($sformatf("v%0d_addr_ack", v), a, vecs[v].exp_ack);
            for (int j = 0; j < vecs[v].nwr; j++) begin
                write_byte(vecs[v].wb[j], a);
                chk($sformatf("v%0d_wr%0d_ack", v, j), a, vecs[v].exp_ack);
            end
            i2c_stop(); hq();
            if (vecs[v].nrd > 0) begin
                i2c_start();
                write_byte(8'h91, a);
                chk($sformatf("v%0d_raddr_ack", v), a, 1'b1);
                for (int j = 0; j < vecs[v].nrd; j++) begin
                    read_byte(b, j == vecs[v].nrd - 1);
                    chk($sformatf("v%0d_rd%0d", v, j), b, vecs[v].exp_rd[j]);
                end
                chk($sformatf("v%0d_sda_rel", v), sda_pin, 1'b1);
                i2c_stop(); hq();
            end
            chk($sformatf("v%0d_config", v), config_reg, vecs[v].exp_cfg);
            chk($sformatf("v%0d_wr_clks", v), wr_hi - wr0, vecs[v].exp_wr);
            chk($sformatf("v%0d_busy_end", v), busy, 1'b0);
            if (!vecs[v].exp_ack)
                chk($sformatf("v%0d_busy_clks", v), busy_hi - busy0, 0);
        end
        // Word latched at read start must not tear when adc_sample changes mid-read.
        i2c_start();
        write_byte(8'h90, a); write_byte(8'h00, a);
        i2c_stop(); hq();
        adc_sample = 16'h1357;
        i2c_start();
        write_byte(8'h91, a);
        read_byte(b, 1'b0);
        adc_sample = 16'hFFFF;
        read_byte(b1, 1'b1);
        i2c_stop(); hq();
        chk("tear_msb", b, 8'h13);
        chk("tear_lsb", b1, 8'h57);
        // Reset asserted while the target is driving the address ACK.
        i2c_start();
        send_bits(8'h90);
        m_oe = 1'b0; hq(); scl = 1'b1; hq();
        chk("ack_driven", sda_pin, 1'b0);
        chk("ack_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_sda", sda_pin, 1'b1);
        chk("rst_mid_config", config_reg, 16'h8583);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_config_wr", config_wr, 1'b0);
        hq();
        reset_n = 1'b1;
        scl = 1'b0; hq();
        i2c_stop(); hq();
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_sda", sda_pin, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adc_i2c_target.md
# adc_i2c_target

Synthesizable I2C target (responder) that emulates the 16-bit register map of the distance-sensor ADC at 7-bit address 0x48. It is the far end of the wall-follower's I2C master link. It serves the pointer/config/conversion protocol from a live 16-bit sample input, so the master FSM can be exercised in closed-loop simulation and on hardware loopback without the physical ADC. It supports no clock stretching and always runs at the master's SCL rate.

## Interface
Parameters:
- TARGET_ADDR, 7'h48, 7-bit address this block answers to.
- CONFIG_RESET, 16'h8583, reset value of the config register.

Ports:
- clk  input  1  system clock (125 MHz nominal).
- reset_n  input  1  one clock; reset is asynchronous and active-low.
- scl_pin  input  1  I2C clock, sampled only.
- sda_pin  inout  1  I2C data, open-drain: driven 0 or left 'z', never driven 1.
- adc_sample  input  16  current conversion value served at pointer 0.
- config_reg  output  16  config register contents.
- config_wr  output  1  one-clock strobe when config_reg is updated.
- busy  output  1  high from a START addressed to this target until STOP or NACK-release.

## Operation
- scl/sda pass through 2-FF synchronizers and one history FF.
- Edge events are computed on synchronized values: scl_rise, scl_fall, start (sda falls while scl high), stop (sda rises while scl high).
- Data is sampled on scl_rise. sda is changed only on scl_fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- IDLE -> ADDR on start. ADDR shifts 8 bits MSB-first (7 address + R/W).
- Address match -> ADDR_ACK: drive sda low for one SCL bit.
  - Then R/W=0 -> PTR.
  - R/W=1 -> RD_DATA, latching the read word: adc_sample if ptr==0, config_reg if ptr==1, 16'h0000 for ptr 2/3.
- Address mismatch -> IGNORE: no drive. Leaves only on start (-> ADDR) or stop (-> IDLE).
- PTR: receive byte. ptr <= byte[1:0], upper bits ignored. ACK, then -> WR_DATA with byte index 0.
- WR_DATA: receive MSB (index 0), ACK, receive LSB (index 1), ACK.
  - On LSB receipt with ptr==1: config_reg <= {MSB,LSB} and pulse config_wr for one clk, at the scl_rise that samples LSB bit 0.
  - Writes to ptr 0/2/3 are ACKed and discarded.
  - Further bytes repeat the MSB/LSB pair on the same register.
- RD_DATA: shift out the latched word MSB byte then LSB byte, bit 7 first; drive 0 bits low, release for 1 bits.
  - RD_ACK: release sda, sample the master bit.
  - Master ACK (0) -> next byte; the byte index wraps LSB->MSB, re-latching a fresh word at the wrap.
  - Master NACK (1) -> IGNORE.
- The pointer persists across transactions. It resets to 0.
- A partial write (STOP/START before the LSB) never updates config_reg.
- Repeated START in any state -> ADDR, releasing sda. STOP in any state -> IDLE, releasing sda.

## Timing
- Reset values:
  - config_reg = CONFIG_RESET, config_wr = 0, busy = 0.
  - ptr = 0, sda released, state IDLE.
  - Synchronizers are reset to 1 (bus idle).
- Latency from a pin edge to a detected event is 3 clk. sda drive changes at the clk after scl_fall is detected, i.e. 3-4 clk after the SCL pin falls. This is well inside the tLOW of 100/400 kHz.
- ACK drive is asserted on the scl_fall ending bit 8 and released on the next scl_fall.
- busy rises the clk after the address-match decision. It falls with stop, or on NACK/IGNORE entry.
- A start and a stop can never coincide (they need opposite sda edges). A start detected in the same clk as scl_fall takes priority.
- reset_n assertion mid-transfer releases sda immediately (asynchronously).

## Test plan
- Write 0x90,0x01,0x42,0x83, STOP -> three ACKs plus address ACK; config_reg=16'h4283; config_wr is high exactly 1 clk.
- Write 0x90,0x00, STOP; adc_sample=16'hABCD; read 0x91 for 2 bytes with ACK then NACK -> bytes 0xAB, 0xCD. sda is released after the NACK. Changing adc_sample mid-read does not tear the word.
- Address 0x92 (0x49 write) -> no ACK (sda stays 'z'), busy stays 0, config_reg unchanged.
- Write 0x90,0x01,0x12 then STOP -> config_reg keeps its previous value; config_wr never pulses.
- Pointer 1, then repeated START with 0x91, read 4 bytes -> 0x85,0x83,0x85,0x83 from the reset config value.
- reset_n low during an ACK bit -> sda released the same cycle; all outputs return to reset values.
